// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for an in-order pipeline.
// Tracks destination tags for DEPTH stages after ID; selects forward at EX.
module fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int FWD_W    = $clog2(DEPTH),
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic [FWD_W-1:0]          id_rdy_class,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [NUM_SRC*FWD_W-1:0]  ex_fwd_sel,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam logic [FWD_W-1:0]  MAX_R = FWD_W'(DEPTH - 2);
  localparam logic [REG_AW-1:0] ZR    = REG_AW'(ZERO_REG);

  logic [DEPTH-1:0]         e_valid;
  logic [DEPTH-1:0]         e_wr;
  logic [REG_AW-1:0]        e_rd [DEPTH];
  logic [FWD_W-1:0]         e_r  [DEPTH];
  logic [NUM_SRC*FWD_W-1:0] next_sel;
  logic [NUM_SRC-1:0]       hazard;
  logic [FWD_W-1:0]         cls;
  logic                     wr_in;
  logic                     ins;

  assign cls   = (id_rdy_class > MAX_R) ? MAX_R : id_rdy_class;
  assign wr_in = id_regwrite && (id_rd != ZR);

  // The last entry writes the regfile this cycle, so it is never searched.
  always_comb begin : resolve
    logic hit;
    int   hj;
    next_sel = '0;
    hazard   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      hit = 1'b0;
      hj  = 0;
      for (int j = DEPTH - 2; j >= 0; j--) begin
        if (id_src_used[k] && e_valid[j] && e_wr[j] &&
            e_rd[j] == id_src[k*REG_AW +: REG_AW]) begin
          hit = 1'b1;
          hj  = j;
        end
      end
      if (hit) begin
        if (hj < int'(e_r[hj]))
          hazard[k] = 1'b1;
        else
          next_sel[k*FWD_W +: FWD_W] = FWD_W'(hj + 1);
      end
    end
  end

  assign stall    = id_valid && !flush && (|hazard);
  assign ins      = id_valid && !flush && !stall;
  assign ex_valid = e_valid[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid    <= '0;
      e_wr       <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        e_rd[j] <= '0;
        e_r[j]  <= '0;
      end
      ex_fwd_sel <= '0;
      stall_cnt  <= '0;
    end else if (!hold) begin
      for (int j = DEPTH - 1; j > 0; j--) begin
        e_valid[j] <= e_valid[j-1];
        e_wr[j]    <= e_wr[j-1];
        e_rd[j]    <= e_rd[j-1];
        e_r[j]     <= e_r[j-1];
      end
      e_valid[0] <= ins;
      e_wr[0]    <= ins && wr_in;
      e_rd[0]    <= id_rd;
      e_r[0]     <= cls;
      ex_fwd_sel <= ins ? next_sel : '0;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit.
// A second instance with a 4-bit counter exercises saturation.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;
  logic       id_valid = 1'b0;
  logic [9:0] id_src = '0;
  logic [1:0] id_src_used = '0;
  logic [4:0] id_rd = '0;
  logic       id_regwrite = 1'b0;
  logic [1:0] id_rdy_class = '0;

  logic        stall, ex_valid;
  logic [3:0]  ex_fwd_sel;
  logic [15:0] stall_cnt;
  logic        stall2, ex_valid2;
  logic [3:0]  ex_fwd_sel2;
  logic [3:0]  cnt2;

  fwd_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_rdy_class(id_rdy_class),
    .stall(stall), .ex_valid(ex_valid), .ex_fwd_sel(ex_fwd_sel),
    .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_rdy_class(id_rdy_class),
    .stall(stall2), .ex_valid(ex_valid2), .ex_fwd_sel(ex_fwd_sel2),
    .stall_cnt(cnt2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cnt_exp = 0;
  int cnt2_exp = 0;
  logic [3:0] sb[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: one expected select per instruction entering EX.
  initial begin : monitor
    logic adv;
    logic [3:0] e;
    forever begin
      @(posedge clk);
      adv = rst_n && !hold;
      @(negedge clk);
      if (adv && rst_n && ex_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ex_unexpected: got ex_valid=1 sel=%0d want bubble",
                   ex_fwd_sel);
        end else begin
          e = sb.pop_front();
          chk("ex_fwd_sel", int'(ex_fwd_sel), int'(e));
        end
      end
    end
  end

  task automatic issue(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic wr, input logic [1:0] cls, input logic fl,
                       input logic hd, input logic exp_st,
                       input logic [3:0] exp_sel);
    id_valid = v;
    id_src = {s1, s0};
    id_src_used = used;
    id_rd = rd;
    id_regwrite = wr;
    id_rdy_class = cls;
    flush = fl;
    hold = hd;
    #1;
    chk("stall", int'(stall), int'(exp_st));
    if (v && !fl && !exp_st && !hd) sb.push_back(exp_sel);
    if (!hd && exp_st) begin
      if (cnt_exp < 65535) cnt_exp++;
      if (cnt2_exp < 15) cnt2_exp++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("stall_cnt", int'(stall_cnt), cnt_exp);
    chk("stall_cnt_sat", int'(cnt2), cnt2_exp);
  endtask

  task automatic op(input logic [4:0] s0, input logic [4:0] s1,
                    input logic [1:0] used, input logic [4:0] rd,
                    input logic wr, input logic [1:0] cls,
                    input logic exp_st, input logic [3:0] exp_sel);
    issue(1'b1, s0, s1, used, rd, wr, cls, 1'b0, 1'b0, exp_st, exp_sel);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      issue(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_ex_valid", int'(ex_valid), 0);
    chk("rst_sel", int'(ex_fwd_sel), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    chk("rst_stall", int'(stall), 0);
    rst_n = 1'b1;
    idle(1);

    // ALU producer -> dependent consumer
    op(5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'd0, 1'b0, 4'b0000);
    op(5'd3, 5'd9, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 4'b0001);
    idle(3);

    // load-use: one stall, bubble, then sel=2 on src1
    op(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'd1, 1'b0, 4'b0000);
    op(5'd1, 5'd4, 2'b10, 5'd0, 1'b0, 2'd0, 1'b1, 4'b0000);
    chk("lu_bubble", int'(ex_valid), 0);
    op(5'd1, 5'd4, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 4'b1000);
    idle(3);

    // zero register, unused source, self-dependency
    op(5'd0, 5'd0, 2'b00, 5'd31, 1'b1, 2'd0, 1'b0, 4'b0000);
    op(5'd31, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 4'b0000);
    op(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd0, 1'b0, 4'b0000);
    op(5'd7, 5'd8, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 4'b0000);
    op(5'd12, 5'd0, 2'b01, 5'd12, 1'b1, 2'd1, 1'b0, 4'b0000);
    idle(3);

    // youngest match wins
    op(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd0, 1'b0, 4'b0000);
    op(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd0, 1'b0, 4'b0000);
    op(5'd5, 5'd5, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0, 4'b0101);
    idle(3);
    op(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd0, 1'b0, 4'b0000);
    op(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd0, 1'b0, 4'b0000);
    idle(1);
    op(5'd5, 5'd5, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0, 4'b1010);
    idle(3);

    // young load hides an older ready ALU result
    op(5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'd0, 1'b0, 4'b0000);
    op(5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'd1, 1'b0, 4'b0000);
    op(5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b1, 4'b0000);
    op(5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 4'b0010);
    idle(3);

    // hold during a load-use stall freezes everything
    op(5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 2'd0, 1'b0, 4'b0000);
    op(5'd2, 5'd0, 2'b01, 5'd4, 1'b1, 2'd1, 1'b0, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0);
      chk("hold_ex_valid", int'(ex_valid), 1);
      chk("hold_sel", int'(ex_fwd_sel), 1);
    end
    op(5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b1, 4'b0000);
    chk("hold_bubble", int'(ex_valid), 0);
    op(5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 4'b0010);
    idle(3);

    // flush beats stall
    op(5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 2'd0, 1'b0, 4'b0000);
    op(5'd2, 5'd0, 2'b01, 5'd4, 1'b1, 2'd1, 1'b0, 4'b0001);
    issue(1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("flush_ex_valid", int'(ex_valid), 0);
    chk("flush_sel", int'(ex_fwd_sel), 0);
    idle(3);

    // repeated load-use pairs drive the 4-bit counter into saturation
    for (int i = 0; i < 14; i++) begin
      op(5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 2'd1, 1'b0, 4'b0000);
      op(5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b1, 4'b0000);
      op(5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 4'b0010);
    end
    chk("sat_final", int'(cnt2), 15);
    chk("cnt_final", int'(stall_cnt), 17);
    idle(2);

    // asynchronous reset in the middle of a stall
    op(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'd1, 1'b0, 4'b0000);
    id_valid = 1'b1;
    id_src = {5'd0, 5'd4};
    id_src_used = 2'b01;
    id_regwrite = 1'b0;
    #1;
    chk("pre_rst_stall", int'(stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", int'(ex_valid), 0);
    chk("arst_sel", int'(ex_fwd_sel), 0);
    chk("arst_cnt", int'(stall_cnt), 0);
    chk("arst_stall", int'(stall), 0);
    sb.delete();
    cnt_exp = 0;
    cnt2_exp = 0;
    id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline forwarding logic.
- Keeps its own shadow pipeline of destination tags for the DEPTH stages after ID.
- At ID, resolves every source operand against that pipeline and either raises a stall (result not yet producible) or registers a forward select that is valid when the instruction reaches EX.
- Also supports per-instruction result latency classes, pipeline hold and flush, and a saturating stall-cycle counter.

Parameters:
- REG_AW, 5: register address width.
- ZERO_REG, 31: register index that never creates a dependency (writes to it are ignored).
- NUM_SRC, 2: source operands per instruction.
- DEPTH, 3: tracked stages after ID; index 0 = EX, 1 = MEM, 2 = WB, ...; minimum 2.
- FWD_W, $clog2(DEPTH): forward-select width.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- hold  in  1  global pipeline freeze (memory wait).
- flush  in  1  kill the instruction in ID (branch redirect).
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  source register indices; src k at bits [k*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  per-source read enable.
- id_rd  in  REG_AW  destination register.
- id_regwrite  in  1  instruction writes id_rd.
- id_rdy_class  in  FWD_W  result-ready class r: 0 = ALU (result at end of EX), 1 = load (end of MEM), ...; values > DEPTH-2 are clamped to DEPTH-2.
- stall  out  1  combinational; hold ID/IF and insert a bubble into EX.
- ex_valid  out  1  entry 0 holds a real instruction.
- ex_fwd_sel  out  NUM_SRC*FWD_W  registered per-source select for the EX operand mux: 0 = register file, k = value from stage k.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Entry state, per index 0..DEPTH-1: valid, rd, wr (regwrite AND rd != ZERO_REG), r (clamped class).
- Match rule: source k matches entry j when id_src_used[k], entry j valid, entry j wr, and entry j rd == src k. Only j = 0..DEPTH-2 are searched. Entry DEPTH-1 writes the register file this cycle, and the register file is write-before-read.
- Priority: the youngest match (smallest j) wins. Older matches are ignored even when they would be ready.
- Per-source decision with winning match j:
  - j < r: hazard for this source.
  - otherwise: next_sel[k] = j+1.
  - no match: next_sel[k] = 0.
- stall = id_valid AND NOT flush AND (any source has a hazard). It is independent of hold.
- Advance cycle (hold=0), on the clock edge:
  - Entries shift: entry j+1 <= entry j.
  - Entry 0 <= ID instruction if id_valid AND NOT flush AND NOT stall; otherwise a bubble (valid=0).
  - ex_fwd_sel <= next_sel if an instruction is inserted; otherwise all zeros.
  - stall_cnt increments when stall=1 and saturates at all ones.
- Hold cycle (hold=1): entries, ex_fwd_sel and stall_cnt keep their values. flush is ignored during hold; its source keeps it asserted until the pipeline advances.
- Latency: the forward select is valid exactly one cycle after the ID decision, aligned with the instruction's EX cycle.
  - ALU producer followed by a dependent consumer: 0 stall cycles, sel=1.
  - Load producer followed by an immediate consumer: 1 stall cycle, then sel=2.
- Simultaneous events:
  - stall and flush together: flush wins, stall=0, bubble inserted.
  - id_src equal to id_rd of the same instruction: no self-dependency.
- Reset (asynchronous, any time including mid-stall): all entries invalid, ex_fwd_sel=0, ex_valid=0, stall_cnt=0. stall then follows its combinational definition, so it is 0 with empty entries.

Test Plan:
- Reset state: assert rst_n=0 mid-stream -> within the same cycle ex_valid=0, ex_fwd_sel=0, stall_cnt=0, stall=0 with id_valid=0.
- ALU-ALU: I1 rd=3 class0, next I2 src0=3 -> stall=0; in I2's EX cycle ex_fwd_sel[src0]=1, src1=0.
- Load-use: I1 rd=4 class1, next I2 src1=4 -> stall=1 for exactly one cycle, bubble in EX, then ex_fwd_sel[src1]=2; stall_cnt=1.
- Zero register / unused: I1 rd=31 writes, I2 src0=31 -> no stall, sel=0. Repeat with id_src_used[0]=0 and rd=7 -> sel=0.
- Youngest priority: I1 rd=5, I2 rd=5, I3 src0=5 src1=5 (all class0) -> both sels=1. With I3 one bubble later -> both sels=2.
- Hold/flush: during load-use stall, assert hold 3 cycles -> stall stays 1, ex_fwd_sel and stall_cnt frozen. Flush on the consumer -> stall=0, bubble inserted, ex_fwd_sel=0. Preload stall_cnt near max -> saturates at 0xFFFF.
